// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: four synchronous byte reads assembled big-endian,
// sharing the memory port with a boot loader enabled by IMEM_FETCH_LOADER_EN.
module imem_fetch_ctrl #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_inst,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

`ifdef IMEM_FETCH_LOADER_EN
  localparam logic LD_EN = 1'b1;
`else
  localparam logic LD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LAST, S_RESP} state_t;

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_word;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_inst;
  logic              r_rsp_err;

  logic              w_idle;
  logic              w_ld_grant;
  logic              w_req_ready;
  logic              w_bad_pc;

  assign w_idle      = !rst && (r_state == S_IDLE);
  // The loader wins the port in IDLE; a pending load holds off fetch acceptance.
  assign w_ld_grant  = LD_EN && ld_valid && w_idle;
  assign w_req_ready = w_idle && !(LD_EN && ld_valid);
  assign w_bad_pc    = (req_pc[1:0] != 2'b00) || ((req_pc >> ADDR_W) != 32'd0);

  assign req_ready = w_req_ready;
  assign ld_ready  = LD_EN && w_idle;
  assign rsp_valid = r_rsp_valid;
  assign rsp_inst  = r_rsp_inst;
  assign rsp_err   = r_rsp_err;

  // Memory port mux: loader write, fetch read address, or all-zero when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    if (w_ld_grant) begin
      mem_we    = 1'b1;
      mem_addr  = ld_addr;
      mem_wdata = ld_data;
    end else if (!rst && (r_state == S_ISSUE)) begin
      mem_addr  = r_pc + ADDR_W'(r_cnt);
    end else begin
      mem_addr  = '0;
    end
  end

  // Fetch sequencer: read data lags the address by one cycle, so byte k lands while cnt==k+1.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_pc        <= '0;
      r_word      <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_inst  <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && w_req_ready) begin
            r_pc   <= req_pc[ADDR_W-1:0];
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
            if (w_bad_pc) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_inst  <= 32'd0;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          case (r_cnt)
            2'd1:    r_word[31:24] <= mem_rdata;
            2'd2:    r_word[23:16] <= mem_rdata;
            2'd3:    r_word[15:8]  <= mem_rdata;
            default: r_word        <= r_word;
          endcase
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state <= S_LAST;
          end
        end
        S_LAST: begin
          r_word      <= {r_word[31:8], mem_rdata};
          r_rsp_inst  <= {r_word[31:8], mem_rdata};
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl with a synchronous-read byte memory model.
module tb_imem_fetch_ctrl;
  localparam int ADDR_W = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, flush;
  logic              ld_valid, ld_ready, mem_we;
  logic [31:0]       req_pc, rsp_inst;
  logic [ADDR_W-1:0] ld_addr, mem_addr;
  logic [7:0]        ld_data, mem_wdata, mem_rdata;

  imem_fetch_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_err(rsp_err),
    .flush(flush), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] inst; logic err; int rise; } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  bit am_en = 1'b0;
  int am_start = 0;
  logic [31:0] am_base = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on rising valid, stability while held, data on handshake, fetch addresses.
  initial begin
    logic        prev_v;
    logic [31:0] prev_inst;
    logic        prev_err;
    exp_t        e;
    prev_v = 1'b0; prev_inst = 32'd0; prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (rsp_valid && !prev_v) begin
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 inst=0x%08h, expected no response (cycle %0d)", rsp_inst, cyc);
          end else begin
            chk("rsp_latency", cyc, sb[0].rise);
          end
        end
        if (rsp_valid && prev_v) begin
          chk("rsp_inst_stable", rsp_inst, prev_inst);
          chk("rsp_err_stable", {31'd0, rsp_err}, {31'd0, prev_err});
        end
        if (rsp_valid && rsp_ready && sb.size() > 0) begin
          e = sb.pop_front();
          chk("rsp_inst", rsp_inst, e.inst);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        end
        if (am_en && cyc >= am_start && cyc < am_start + 4)
          chk("mem_addr_seq", {23'd0, mem_addr}, (am_base + 32'(cyc - am_start)) & 32'h1FF);
        prev_v = rsp_valid; prev_inst = rsp_inst; prev_err = rsp_err;
      end
    end
  end

  task automatic issue(input logic [31:0] pc, input logic [31:0] einst, input logic eerr,
                       output int waited);
    bit   ok;
    exp_t e;
    ok = 1'b0; waited = 0;
    req_valid = 1'b1; req_pc = pc;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        e.inst = einst; e.err = eerr; e.rise = cyc + (eerr ? 1 : 6);
        sb.push_back(e);
        am_en = !eerr; am_start = cyc + 1; am_base = pc;
      end else begin
        waited++;
        @(posedge clk); #1;
      end
    end
    chk("fetch_accepted", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (eerr) begin
      @(negedge clk);
      chk("err_no_mem_addr", {23'd0, mem_addr}, 32'd0);
      chk("err_no_mem_we", {31'd0, mem_we}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 32'd0);
    am_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_ld_ready"}, {31'd0, ld_ready}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {23'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_inst"}, rsp_inst, 32'd0);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
  endtask

  initial begin
    int  w;
    bit  got;
    logic [7:0] ld_bytes [4];
    ld_bytes[0] = 8'h00; ld_bytes[1] = 8'h10; ld_bytes[2] = 8'h00; ld_bytes[3] = 8'h93;
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 8'h00;
    mem[16] = 8'hDE; mem[17] = 8'hAD; mem[18] = 8'hBE; mem[19] = 8'hEF;
`ifndef IMEM_FETCH_LOADER_EN
    for (int i = 0; i < 4; i++) mem[8 + i] = ld_bytes[i];
`endif
    rst = 1'b1; flush = 1'b0; req_valid = 1'b1; req_pc = 32'h8; rsp_ready = 1'b1;
    ld_valid = 1'b1; ld_addr = 9'h8; ld_data = 8'hFF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

`ifdef IMEM_FETCH_LOADER_EN
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_addr = 9'(8 + i); ld_data = ld_bytes[i];
      @(negedge clk);
      chk("ld_ready", {31'd0, ld_ready}, 32'd1);
      chk("ld_mem_we", {31'd0, mem_we}, 32'd1);
      chk("ld_mem_addr", {23'd0, mem_addr}, 32'(8 + i));
      chk("ld_mem_wdata", {24'd0, mem_wdata}, {24'd0, ld_bytes[i]});
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
`endif

    issue(32'h8, 32'h00100093, 1'b0, w);
    drain();
    issue(32'h6, 32'h0, 1'b1, w);
    drain();
    issue(32'h200, 32'h0, 1'b1, w);
    drain();

    // Response backpressure: three stalled RESP cycles then handshake.
    rsp_ready = 1'b0;
    issue(32'h10, 32'hDEADBEEF, 1'b0, w);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = rsp_valid;
    end
    chk("bp_rsp_seen", {31'd0, got}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("bp_hold_c2", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("bp_hold_c3", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hold_c4", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_req_ready_after", {31'd0, req_ready}, 32'd1);
    chk("bp_rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
    chk("bp_drain", sb.size(), 32'd0);
    am_en = 1'b0;
    @(posedge clk); #1;

`ifdef IMEM_FETCH_LOADER_EN
    ld_valid = 1'b1; ld_addr = 9'h20; ld_data = 8'h55; req_valid = 1'b1; req_pc = 32'h10;
    @(negedge clk);
    chk("sim_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("sim_req_ready", {31'd0, req_ready}, 32'd0);
    chk("sim_mem_we", {31'd0, mem_we}, 32'd1);
    @(posedge clk); #1; ld_valid = 1'b0;
    issue(32'h10, 32'hDEADBEEF, 1'b0, w);
    chk("sim_accept_first_free", w, 32'd0);
    drain();
    issue(32'h8, 32'h00100093, 1'b0, w);
    ld_valid = 1'b1; ld_addr = 9'h30; ld_data = 8'hFF;
    @(negedge clk);
    chk("stall_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("stall_mem_we", {31'd0, mem_we}, 32'd0);
    drain();
    @(negedge clk);
    chk("stall_release_ld_ready", {31'd0, ld_ready}, 32'd1);
    @(posedge clk); #1; ld_valid = 1'b0;
`else
    ld_valid = 1'b1; ld_addr = 9'h8; ld_data = 8'hFF;
    @(negedge clk);
    chk("noload_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("noload_mem_we", {31'd0, mem_we}, 32'd0);
    chk("noload_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    issue(32'h8, 32'h00100093, 1'b0, w);
    chk("noload_accept_now", w, 32'd0);
    drain();
    ld_valid = 1'b0;
`endif

    // Flush in the second ISSUE cycle.
    issue(32'h8, 32'h00100093, 1'b0, w);
    @(posedge clk); #1; flush = 1'b1; sb.delete(); am_en = 1'b0;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    chk("flush_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("flush_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;

    // Reset in the second ISSUE cycle.
    issue(32'h10, 32'hDEADBEEF, 1'b0, w);
    @(posedge clk); #1; rst = 1'b1; sb.delete(); am_en = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_addr", {23'd0, mem_addr}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    all_zero("rst_mid");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch controller for the byte-wide instruction memory. It accepts word-fetch requests from the core's fetch stage and sequences four byte reads from a single-port, synchronous-read byte memory. It assembles the bytes big-endian into a 32-bit instruction and returns it over a valid/ready handshake. It also arbitrates that single memory port with a byte-wide program loader used to fill memory at boot.

## Interface
Parameters:
- `ADDR_W`, default 9, byte-address width of the memory (2^ADDR_W bytes; 512 by default).

Ports:
- `clk`, input, 1, sole clock. All state changes on the rising edge.
- `rst`, input, 1, reset. Synchronous, active-high.
- `req_valid`, input, 1, fetch request valid.
- `req_ready`, output, 1, controller can accept a fetch.
- `req_pc`, input, 32, byte address of the instruction.
- `rsp_valid`, output, 1, instruction response valid.
- `rsp_ready`, input, 1, consumer accepts the response.
- `rsp_inst`, output, 32, assembled instruction.
- `rsp_err`, output, 1, fetch was misaligned or out of range.
- `flush`, input, 1, abort any in-flight fetch or pending response.
- `ld_valid`, input, 1, loader write valid.
- `ld_ready`, output, 1, loader write accepted this cycle.
- `ld_addr`, input, ADDR_W, loader byte address.
- `ld_data`, input, 8, loader byte.
- `mem_addr`, output, ADDR_W, memory byte address.
- `mem_we`, output, 1, memory write enable.
- `mem_wdata`, output, 8, memory write data.
- `mem_rdata`, input, 8, read data. Valid one cycle after `mem_addr` is presented.

## Operation
- The FSM has four states: IDLE, ISSUE, LAST and RESP. A 2-bit byte counter `cnt` runs in ISSUE.
- **IDLE, loader has priority:**
  - `ld_ready = !rst && state==IDLE`.
  - `req_ready = !rst && state==IDLE && !ld_valid`.
- **Loader write:** when `ld_valid && ld_ready`, drive `mem_we=1`, `mem_addr=ld_addr`, `mem_wdata=ld_data` combinationally. The write takes effect at that edge.
- **Fetch accept:** on `req_valid && req_ready`, latch `req_pc`.
  - If `req_pc[1:0]!=0` or `req_pc[31:ADDR_W]!=0`: go directly to RESP with `rsp_inst=0` and `rsp_err=1`. No memory access is made.
  - Otherwise: go to ISSUE with `cnt=0` and clear the assembly register.
- **ISSUE:**
  - Drive `mem_addr = pc[ADDR_W-1:0] + cnt`.
  - When `cnt>=1`, capture `mem_rdata` into byte `cnt-1` of the word.
  - Increment `cnt`. After issuing `cnt==3`, go to LAST.
- **LAST:** capture byte 3, then go to RESP.
- **Byte order:** `rsp_inst = {mem[pc], mem[pc+1], mem[pc+2], mem[pc+3]}`. Byte 0 is bits [31:24].
- **RESP:** `rsp_valid=1`, with `rsp_inst` and `rsp_err` held stable. On `rsp_ready`, go to IDLE.
- **Flush:** `flush` in any state returns the FSM to IDLE at the next edge.
  - Drops the latched request and any response. `rsp_valid` is low the following cycle.
  - `flush` has priority over accept in IDLE: no request is accepted in a flush cycle.
- **Idle memory signals:** when no write is granted and not in ISSUE, `mem_addr=0`, `mem_we=0`, `mem_wdata=0`.
- **Arithmetic:** address addition is modulo 2^ADDR_W. Wrap cannot occur for aligned in-range PCs.

## Timing
- **Reset values** (while `rst` is high and at the first edge): state IDLE, `cnt=0`, `rsp_valid=0`, `rsp_inst=0`, `rsp_err=0`. `req_ready`, `ld_ready`, `mem_we`, `mem_addr` and `mem_wdata` are all 0.
- **Reset mid-fetch:** `rst` asserted during ISSUE, LAST or RESP discards the fetch exactly as a flush does.
- **Valid fetch latency:** with acceptance in cycle T, `mem_addr` presents pc+0..pc+3 in cycles T+1..T+4. `rsp_valid` rises in cycle T+6.
- **Error fetch latency:** `rsp_valid` rises in cycle T+1.
- **Throughput:**
  - Back-to-back fetches: one per 7 cycles. The response handshake is in cycle T+6 and the next accept is in T+7.
  - Loader: one byte per cycle while IDLE.
- **Loader stall:** `ld_valid` during ISSUE, LAST or RESP is stalled (`ld_ready=0`) until IDLE. The loader never corrupts an in-flight fetch.

## Configuration
- `IMEM_FETCH_LOADER_EN` defined: loader port is functional as described.
- Not defined:
  - `ld_ready` is tied to 0 and `mem_we`/`mem_wdata` are tied to 0.
  - `req_ready = !rst && state==IDLE`, regardless of `ld_valid`.
  - `ld_*` inputs are ignored. Ports remain present.

## Test plan
- **Load then fetch:** load bytes 0x00, 0x10, 0x00, 0x93 at 0x8–0xB. Fetch pc=0x8 → `rsp_inst=0x00100093`, `rsp_err=0`. `rsp_valid` first high 6 cycles after accept; `mem_addr` sequence 0x8, 0x9, 0xA, 0xB.
- **Error fetches:** fetch pc=0x6 → `rsp_valid` one cycle after accept, `rsp_inst=0`, `rsp_err=1`, no `mem_addr` activity. pc=0x200 (ADDR_W=9) → same result.
- **Simultaneous loader and fetch:** `ld_valid` and `req_valid` both high in IDLE → `ld_ready=1`, `req_ready=0`, write occurs. The fetch is accepted in the first cycle `ld_valid` is low.
- **Response backpressure:** hold `rsp_ready=0` for 3 cycles in RESP → `rsp_valid` and `rsp_inst` stay stable. Handshake on the 4th cycle, and `req_ready=1` the next cycle.
- **Flush and reset mid-fetch:** assert `flush` in the 2nd ISSUE cycle → IDLE the next cycle, no `rsp_valid`, `req_ready=1`. Repeat with `rst` instead → all outputs 0 the following cycle.
- **Macro undefined:** `ld_valid=1` with `ld_addr=0x8`, `ld_data=0xFF` → `ld_ready=0`, `mem_we=0`. A concurrent fetch is accepted.
